dlf_update_scheduler: RTL and testbench
=======================================

# dlf_update_scheduler

Sequencer in front of the 8-bit digital loop filter. It integrates lead/lag events from the phase detector in a signed up/down counter. When the count crosses a threshold, it issues one correction word plus a direction bit to the loop filter over a valid/ready handshake. It also adapts the correction step (halve on reversal, double on repeat), enforces a hold-off after each update, and reports lock and overrun status to the control block.

## Interface
Parameters:
- `THRESH`, 8: counter magnitude that triggers a correction; legal range 2..127.
- `HOLDOFF`, 4: idle cycles after each completed correction; 0 allowed.
- `LOCK_EVENTS`, 32: accepted events without a correction before `locked` asserts.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: pulse; loads `cfg_step`, clears the counter, and arms the block.
- `cfg_step`, in, 8: maximum/initial correction step; a value of 0 is treated as 1.
- `pd_valid`, in, 1: phase-detector event strobe, one event per cycle.
- `pd_lead`, in, 1: event direction; 1 = lead (+1), 0 = lag (−1).
- `dlf_valid`, out, 1: correction offered to the loop filter.
- `dlf_ready`, in, 1: loop filter accepts the correction.
- `dlf_master_in`, out, 8: correction magnitude (current step).
- `dlf_lead`, out, 1: correction direction.
- `locked`, out, 1: no correction for `LOCK_EVENTS` accepted events.
- `overrun`, out, 1: sticky; an event arrived while it could not be accepted.

## Operation
- States:
  - IDLE (after reset): events are ignored; `start` → ACCUM.
  - ACCUM: integrates events.
  - ISSUE: `dlf_valid` = 1.
  - HOLD: counts `HOLDOFF` cycles, then → ACCUM.
- Counter `acc`: signed, width `$clog2(THRESH)+2`. In ACCUM, each `pd_valid` adds +1 (lead) or −1 (lag).
  - The event that makes `acc` reach +`THRESH` → ISSUE with direction 1.
  - Reaching −`THRESH` → ISSUE with direction 0.
  - `acc` is cleared on entering ISSUE.
- Step register `step` is loaded by `start` with max(`cfg_step`, 1). At each threshold crossing the new step is computed, latched into `step`, and driven on `dlf_master_in` for that correction:
  - First correction after `start`: unchanged.
  - Direction differs from the previous correction: `step` = max(`step`>>1, 1).
  - Same direction: `step` = min(`step`<<1, `cfg_step`), saturating with no overflow past 8 bits.
- ISSUE holds `dlf_valid`, `dlf_master_in` and `dlf_lead` stable until `dlf_valid` & `dlf_ready`. On that transfer: HOLD if `HOLDOFF` > 0, otherwise ACCUM.
- `pd_valid` in ISSUE or HOLD: the event is dropped, `overrun` ← 1, `acc` unchanged.
- `lock_cnt` counts events accepted in ACCUM and saturates at `LOCK_EVENTS`. `locked` = (`lock_cnt` == `LOCK_EVENTS`). `lock_cnt` is cleared on entering ISSUE, on `start`, and on `rst`.
- `start` handling:
  - Honoured in IDLE, ACCUM and HOLD: reloads `step`, clears `acc`, `lock_cnt`, `overrun` and previous-direction history, then → ACCUM.
  - Ignored in ISSUE, so a pending offer is never withdrawn.
- Simultaneous `start` and `pd_valid` in ACCUM: `start` wins and the event is discarded; `overrun` is not set.

## Timing
- Reset values: `dlf_valid` = 0, `dlf_master_in` = 0, `dlf_lead` = 0, `locked` = 0, `overrun` = 0, state = IDLE. Reset takes effect immediately, including mid-ISSUE.
- Threshold-crossing event in cycle n → `dlf_valid` = 1 in cycle n+1. All outputs are registered.
- Transfer in cycle m → `dlf_valid` = 0 in cycle m+1.
  - HOLD then occupies cycles m+1 .. m+`HOLDOFF`.
  - Events are accepted again from cycle m+`HOLDOFF`+1.
- `dlf_master_in` and `dlf_lead` keep the last issued value outside ISSUE.
- `locked` and `overrun` update one cycle after the causing event.

## Structure
- Package `dlf_ctrl_pkg`: state enum (IDLE/ACCUM/ISSUE/HOLD), direction constants `DIR_LAG` = 0 and `DIR_LEAD` = 1, step width constant 8.
- Sub-module `dlf_step_adapter` (combinational): inputs `step`, `cfg_step`, previous direction, history-valid flag and new direction; output is the next step.
- The FSM, counters and handshake live in the top module.

## Test plan
All scenarios use `THRESH` = 4, `HOLDOFF` = 2, `LOCK_EVENTS` = 32, `cfg_step` = 16.
1. Reset, then 10 `pd_valid` events before `start` → all outputs stay 0 and the state stays IDLE.
2. `start`, then 4 lead events on consecutive cycles → `dlf_valid` = 1 the cycle after the 4th, `dlf_lead` = 1, `dlf_master_in` = 16. With `dlf_ready` low for 3 cycles the outputs stay stable; when ready is raised, `dlf_valid` drops the next cycle.
3. Continue after scenario 2 with:
   - 4 lags → correction 8, lag.
   - 4 lags → correction 16 (8<<1 capped at 16).
   - 4 leads → correction 8, lead.
   - With `cfg_step` = 1, 4 lags → 1 (floor) after the reversal.
4. Events lead, lag, lead, lead, lead, lead → `acc` = 1, 0, 1, 2, 3, 4; correction issued after the 6th event. A `pd_valid` during the 2 HOLD cycles → `overrun` = 1 and `acc` stays 0; a following `start` clears `overrun`.
5. 32 alternating lead/lag events → `locked` = 1 the cycle after the 32nd. A subsequent 4-lead run → `locked` = 0 when ISSUE is entered.
6. Assert `rst` while in ISSUE with `dlf_valid` = 1 → `dlf_valid` = 0 immediately without waiting for a clock edge. After reset release the state is IDLE and `start` is required before any further correction.

Source files
------------

// File: rtl/dlf_ctrl_pkg.sv
// Shared types and constants for the loop-filter update scheduler.
// Holds the FSM state encoding, the correction directions and the correction-step width.
package dlf_ctrl_pkg;

  localparam int STEP_W = 8;

  localparam logic DIR_LAG  = 1'b0;
  localparam logic DIR_LEAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dlf_step_adapter.sv
// Combinational next-step rule: halve on reversal, double on repeat, capped at cfg_step.
// Zero latency; no handshake. The result is only latched at a threshold crossing.
module dlf_step_adapter
  import dlf_ctrl_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              prev_dir,
  input  logic              hist_vld,
  input  logic              new_dir,
  output logic [STEP_W-1:0] next_step
);

  logic [STEP_W-1:0] cap;
  logic [STEP_W-1:0] half;
  logic [STEP_W:0]   dbl;

  always_comb begin
    cap  = (cfg_step == '0) ? STEP_W'(1) : cfg_step;
    half = step >> 1;
    if (half == '0) half = STEP_W'(1);
    // One extra bit so doubling a large step saturates instead of wrapping.
    dbl  = {1'b0, step} << 1;

    next_step = step;
    if (hist_vld) begin
      if (new_dir != prev_dir) next_step = half;
      else if (dbl > {1'b0, cap}) next_step = cap;
      else next_step = dbl[STEP_W-1:0];
    end
  end

endmodule

// File: rtl/dlf_update_scheduler.sv
// Integrates lead/lag events and, on a threshold crossing, offers one step-adapted correction.
// Offer appears the cycle after the crossing and is held until dlf_ready; events arriving then are dropped and flagged.
module dlf_update_scheduler
  import dlf_ctrl_pkg::*;
#(
  parameter int THRESH      = 8,
  parameter int HOLDOFF     = 4,
  parameter int LOCK_EVENTS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              pd_valid,
  input  logic              pd_lead,
  output logic              dlf_valid,
  input  logic              dlf_ready,
  output logic [STEP_W-1:0] dlf_master_in,
  output logic              dlf_lead,
  output logic              locked,
  output logic              overrun
);

  localparam int AW = $clog2(THRESH) + 2;
  localparam int LW = $clog2(LOCK_EVENTS + 1);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic signed [AW-1:0] ACC_ONE   = AW'(1);
  localparam logic signed [AW-1:0] POS_T     = AW'(THRESH);
  localparam logic signed [AW-1:0] NEG_T     = -POS_T;
  localparam logic [LW-1:0]        LOCK_MAX  = LW'(LOCK_EVENTS);
  localparam logic [HW-1:0]        HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  state_t state, state_nx;

  logic signed [AW-1:0] acc, acc_inc;
  logic [LW-1:0]        lock_cnt, lock_nx;
  logic [HW-1:0]        hold_cnt;
  logic [STEP_W-1:0]    step, step_nx;
  logic                 prev_dir, hist_vld;
  logic                 start_ok, ev_acc, hit, new_dir, xfer;

  always_comb begin
    start_ok = start && (state != ISSUE);
    ev_acc   = (state == ACCUM) && pd_valid && !start;
    acc_inc  = pd_lead ? (acc + ACC_ONE) : (acc - ACC_ONE);
    hit      = ev_acc && ((acc_inc == POS_T) || (acc_inc == NEG_T));
    new_dir  = pd_lead ? DIR_LEAD : DIR_LAG;
    xfer     = (state == ISSUE) && dlf_ready;
    lock_nx  = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
  end

  dlf_step_adapter u_step_adapter (
    .step      (step),
    .cfg_step  (cfg_step),
    .prev_dir  (prev_dir),
    .hist_vld  (hist_vld),
    .new_dir   (new_dir),
    .next_step (step_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACCUM;
      ACCUM:   if (!start && hit) state_nx = ISSUE;
      ISSUE:   if (dlf_ready) state_nx = (HOLDOFF > 0) ? HOLD : ACCUM;
      HOLD:    if (start || hold_cnt == '0) state_nx = ACCUM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dlf_valid = (state == ISSUE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      lock_cnt      <= '0;
      hold_cnt      <= '0;
      step          <= '0;
      prev_dir      <= DIR_LAG;
      hist_vld      <= 1'b0;
      dlf_master_in <= '0;
      dlf_lead      <= DIR_LAG;
      locked        <= 1'b0;
      overrun       <= 1'b0;
    end else if (start_ok) begin
      acc      <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
      overrun  <= 1'b0;
      hist_vld <= 1'b0;
      step     <= (cfg_step == '0) ? STEP_W'(1) : cfg_step;
    end else begin
      if (hit) begin
        acc           <= '0;
        lock_cnt      <= '0;
        locked        <= 1'b0;
        step          <= step_nx;
        dlf_master_in <= step_nx;
        dlf_lead      <= new_dir;
        prev_dir      <= new_dir;
        hist_vld      <= 1'b1;
      end else if (ev_acc) begin
        acc      <= acc_inc;
        lock_cnt <= lock_nx;
        locked   <= (lock_nx == LOCK_MAX);
      end
      if (pd_valid && (state == ISSUE || state == HOLD)) overrun <= 1'b1;
      if (xfer) hold_cnt <= HOLD_LOAD;
      else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_dlf_update_scheduler.sv
// Directed bench for dlf_update_scheduler with THRESH=4, HOLDOFF=2, LOCK_EVENTS=32.
// Expected corrections are queued by the stimulus and compared by a monitor at each handshake.
module tb_dlf_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_step;
  logic       pd_valid;
  logic       pd_lead;
  logic       dlf_valid;
  logic       dlf_ready;
  logic [7:0] dlf_master_in;
  logic       dlf_lead;
  logic       locked;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  dlf_update_scheduler #(.THRESH(4), .HOLDOFF(2), .LOCK_EVENTS(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_step      (cfg_step),
    .pd_valid      (pd_valid),
    .pd_lead       (pd_lead),
    .dlf_valid     (dlf_valid),
    .dlf_ready     (dlf_ready),
    .dlf_master_in (dlf_master_in),
    .dlf_lead      (dlf_lead),
    .locked        (locked),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted correction must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && dlf_valid && dlf_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got lead=%0d mag=%0d, required no transfer", dlf_lead, dlf_master_in);
      end else begin
        mon_e = exp_q.pop_front();
        if ({dlf_lead, dlf_master_in} !== mon_e) begin
          errors++;
          $display("FAIL xfer_word: got lead=%0d mag=%0d, required lead=%0d mag=%0d",
                   dlf_lead, dlf_master_in, mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic lead);
    pd_valid = 1'b1;
    pd_lead  = lead;
    cyc();
    pd_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Transfer the pending offer, check it drops, then sit out the hold-off.
  task automatic xfer(input string name);
    dlf_ready = 1'b1;
    cyc();
    dlf_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(dlf_valid), 0);
    repeat (2) cyc();
  endtask

  // Four same-direction events from acc=0 must produce exactly one offer of (lead, mag).
  task automatic run4(input logic lead, input logic [7:0] mag, input string name);
    exp_q.push_back({lead, mag});
    for (int i = 0; i < 3; i++) begin
      send(lead);
      check({name, "_early"}, 32'(dlf_valid), 0);
    end
    send(lead);
    check({name, "_valid"}, 32'(dlf_valid), 1);
    check({name, "_lead"}, 32'(dlf_lead), 32'(lead));
    check({name, "_mag"}, 32'(dlf_master_in), 32'(mag));
    xfer(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_step = 8'd16;
    pd_valid = 1'b0; pd_lead = 1'b0; dlf_ready = 1'b0;
    repeat (2) cyc();
    check("rst_valid", 32'(dlf_valid), 0);
    check("rst_mag", 32'(dlf_master_in), 0);
    check("rst_lead", 32'(dlf_lead), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    cyc();

    // Events before start are ignored entirely.
    for (int i = 0; i < 10; i++) begin
      send(1'b1);
      check("idle_valid", 32'(dlf_valid), 0);
    end
    check("idle_mag", 32'(dlf_master_in), 0);
    check("idle_lead", 32'(dlf_lead), 0);
    check("idle_locked", 32'(locked), 0);
    check("idle_overrun", 32'(overrun), 0);

    // First correction, with a 3-cycle stall on dlf_ready.
    do_start();
    exp_q.push_back({1'b1, 8'd16});
    for (int i = 0; i < 3; i++) begin
      send(1'b1);
      check("s2_early", 32'(dlf_valid), 0);
    end
    send(1'b1);
    for (int i = 0; i < 4; i++) begin
      check("s2_valid", 32'(dlf_valid), 1);
      check("s2_lead", 32'(dlf_lead), 1);
      check("s2_mag", 32'(dlf_master_in), 16);
      if (i < 3) cyc();
    end
    xfer("s2");
    check("s2_mag_kept", 32'(dlf_master_in), 16);

    // Step adaptation: reversal halves, repeat doubles up to cfg_step.
    run4(1'b0, 8'd8, "s3_rev");
    run4(1'b0, 8'd16, "s3_dbl");
    run4(1'b1, 8'd8, "s3_rev2");
    cfg_step = 8'd1;
    do_start();
    run4(1'b1, 8'd1, "s3_min_first");
    run4(1'b0, 8'd1, "s3_min_floor");
    cfg_step = 8'd16;

    // Mixed events, then an event dropped during hold-off.
    do_start();
    exp_q.push_back({1'b1, 8'd16});
    send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b1);
    check("s4_early", 32'(dlf_valid), 0);
    send(1'b1);
    check("s4_valid", 32'(dlf_valid), 1);
    dlf_ready = 1'b1;
    cyc();
    dlf_ready = 1'b0;
    check("s4_drop", 32'(dlf_valid), 0);
    check("s4_ovr_pre", 32'(overrun), 0);
    send(1'b1);
    check("s4_overrun", 32'(overrun), 1);
    cyc();
    check("s4_overrun_sticky", 32'(overrun), 1);
    run4(1'b1, 8'd16, "s4_acc_kept");
    do_start();
    check("s4_overrun_clr", 32'(overrun), 0);

    // Lock after 32 non-crossing events, lost on the next correction.
    for (int i = 0; i < 32; i++) begin
      send((i % 2) == 0);
      if (i == 30) check("s5_not_locked", 32'(locked), 0);
    end
    check("s5_locked", 32'(locked), 1);
    check("s5_no_valid", 32'(dlf_valid), 0);
    exp_q.push_back({1'b1, 8'd16});
    send(1'b1); send(1'b1); send(1'b1);
    check("s5_locked_hold", 32'(locked), 1);
    send(1'b1);
    check("s5_valid", 32'(dlf_valid), 1);
    check("s5_unlocked", 32'(locked), 0);
    xfer("s5");

    // Asynchronous reset mid-offer.
    for (int i = 0; i < 4; i++) send(1'b0);
    check("s6_valid", 32'(dlf_valid), 1);
    rst = 1'b1;
    #1;
    check("s6_async_valid", 32'(dlf_valid), 0);
    check("s6_async_mag", 32'(dlf_master_in), 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      check("s6_idle_valid", 32'(dlf_valid), 0);
    end
    check("s6_idle_overrun", 32'(overrun), 0);
    do_start();
    run4(1'b1, 8'd16, "s6_restart");

    cyc();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
